multi_edge_pulser: RTL and testbench
====================================

# multi_edge_pulser

Parametrised, multi-channel successor to the single-pulse rising-edge detector. Each of `NCH` asynchronous inputs is synchronised, debounced and edge-qualified per a run-time mode (rise/fall/both/off), then emits a registered pulse of `PULSE_LEN` clocks. It sits between raw board inputs (buttons, switches, sensor strobes) and the control FSMs that consume one-shot events.

## Interface
- `NCH`, default 4: number of independent channels (≥1).
- `SYNC_STAGES`, default 2: synchroniser flops per channel (≥2).
- `DB_CYCLES`, default 4: consecutive stable cycles required to accept a level change (≥1).
- `PULSE_LEN`, default 1: output pulse width in clocks (≥1).
- `clk`  in  1: sole clock, all flops on posedge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `din`  in  [NCH-1:0]: raw asynchronous inputs.
- `mode`  in  edge_mode_t [NCH-1:0]: per-channel edge select; 2'b00 off, 2'b01 rise, 2'b10 fall, 2'b11 both.
- `d_pulse`  out  [NCH-1:0]: registered one-shot per channel.
- `d_level`  out  [NCH-1:0]: debounced level per channel.
- `any_pulse`  out  1: OR of `d_pulse`.

## Operation
- Per channel, three stages: synchroniser → debouncer → edge/pulse generator. Channels fully independent.
- Synchroniser: `SYNC_STAGES`-deep shift register; last stage is `s`.
- Debouncer: counter `cnt`, width $clog2(DB_CYCLES+1).
  - `s == d_level`: `cnt` ← 0.
  - `s != d_level`, `cnt < DB_CYCLES-1`: `cnt` ← `cnt`+1.
  - `s != d_level`, `cnt == DB_CYCLES-1`: `d_level` ← `s`, `cnt` ← 0 (accept edge).
  - Any glitch shorter than `DB_CYCLES` cycles at `s` produces no level change and no pulse.
- Edge qualification at the accepting edge: rise = 0→1, fall = 1→0; qualified if the corresponding `mode` bit is set. `mode` is sampled only at that edge.
- Pulse generator: down-counter `pcnt`, width $clog2(PULSE_LEN+1). Qualified edge loads `pcnt` ← `PULSE_LEN`; otherwise decrement while nonzero. `d_pulse` is a flop set on load and held while `pcnt` > 1 after load; net effect: high for exactly `PULSE_LEN` cycles.
- Retrigger: qualified edge while pulse active reloads `PULSE_LEN`; pulse extends, never produces a gap.
- Mode change while pulse active: active pulse completes unchanged. `mode` = off: `d_level` still tracks; no pulses.
- Reset: all synchroniser flops, `d_level`, `cnt`, `pcnt`, `d_pulse` ← 0 asynchronously; `any_pulse` = 0. Reset mid-pulse truncates it. Inputs high at reset release are seen as a rising edge after normal latency.

## Timing
- `din` change stable before posedge 1: `s` changes after posedge `SYNC_STAGES`; `d_level` and `d_pulse` rise after posedge `SYNC_STAGES + DB_CYCLES`. Defaults: 6 cycles.
- Minimum configuration (`SYNC_STAGES`=2, `DB_CYCLES`=1, `PULSE_LEN`=1): 3-cycle latency, 1-cycle pulse.
- `d_pulse` and `d_level` are direct flop outputs; `any_pulse` is one OR level after flops.
- Minimum spacing between accepted edges on one channel: `DB_CYCLES` cycles.

## Structure
- `multi_edge_pulser_pkg`: `edge_mode_t` enum (EDGE_OFF, EDGE_RISE, EDGE_FALL, EDGE_BOTH), bit positions `MODE_RISE_BIT`=0 and `MODE_FALL_BIT`=1.
- Sub-module `edge_pulser_ch`: one channel (sync + debounce + pulse), same parameters minus `NCH`; top is a generate loop plus `any_pulse` OR.

## Test plan
- Defaults, ch0 rise mode, `din[0]` 0→1 held: `d_level[0]` and `d_pulse[0]` rise 6 cycles later; pulse exactly 1 cycle; other channels stay 0.
- `DB_CYCLES`=4, 3-cycle high glitch on `din[1]`: no `d_level[1]` change, no pulse; 4-cycle high: accepted.
- Ch2 both mode, `PULSE_LEN`=3: rise then fall 8 cycles apart → two 3-cycle pulses; fall mode → only the second pulse.
- `PULSE_LEN`=5, `DB_CYCLES`=1, both mode, toggle every 2 cycles: `d_pulse` stays continuously high until 5 cycles after last accepted edge.
- `mode` off on ch3, toggle `din[3]`: `d_level[3]` follows, `d_pulse[3]`=0, `any_pulse`=0.
- Assert `rst_n` low mid-pulse: all outputs 0 immediately (async); after release with `din` high, rising pulse after 6 cycles.

Source files
------------

// File: rtl/multi_edge_pulser_pkg.sv
// Shared types for the multi-channel edge pulser.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// edge_mode_t : per-channel edge select (off / rise / fall / both)
// MODE_*_BIT  : bit positions inside edge_mode_t that enable each edge polarity
package multi_edge_pulser_pkg;

    typedef enum logic [1:0] {
        EDGE_OFF  = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_t;

    localparam int MODE_RISE_BIT = 0;
    localparam int MODE_FALL_BIT = 1;

endpackage

// File: rtl/edge_pulser_ch.sv
// One channel: synchroniser -> debouncer -> edge-qualified pulse generator.
// Latency: din change to d_level/d_pulse is SYNC_STAGES + DB_CYCLES clocks.
// Backpressure: none; the input is sampled every clock and events are never stalled.
//
// Ports:
//   clk, rst_n : clock (posedge) and asynchronous active-low reset
//   din        : raw asynchronous input
//   mode       : edge select, looked at only on the clock that accepts a level change
//   d_pulse    : registered one-shot, high for PULSE_LEN clocks per qualified edge
//   d_level    : debounced level
module edge_pulser_ch
    import multi_edge_pulser_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 4,
    parameter int PULSE_LEN   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       din,
    input  edge_mode_t mode,
    output logic       d_pulse,
    output logic       d_level
);

    localparam int CNT_W  = $clog2(DB_CYCLES + 1);
    localparam int PCNT_W = $clog2(PULSE_LEN + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DB_CYCLES - 1);
    localparam logic [PCNT_W-1:0] PCNT_LOAD = PCNT_W'(PULSE_LEN);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [CNT_W-1:0]       cnt;
    logic [PCNT_W-1:0]      pcnt;
    logic [1:0]             mode_bits;
    logic                   accept;
    logic                   load;

    assign s         = sync_q[SYNC_STAGES-1];
    assign mode_bits = mode;

    // A level change is accepted on the DB_CYCLES-th consecutive clock that s
    // disagrees with the current debounced level.
    assign accept = (s != d_level) && (cnt == CNT_LAST);

    // The new level equals s, so s itself tells the polarity of the edge.
    assign load = accept && (s ? mode_bits[MODE_RISE_BIT] : mode_bits[MODE_FALL_BIT]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            d_level <= 1'b0;
        end else if (s == d_level) begin
            cnt <= '0;
        end else if (accept) begin
            cnt     <= '0;
            d_level <= s;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // pcnt holds the number of pulse cycles still owed including the current
    // one, so the pulse flop stays high while more than one remains. A reload
    // while active simply restarts the count, giving a gap-free extension.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt    <= '0;
            d_pulse <= 1'b0;
        end else if (load) begin
            pcnt    <= PCNT_LOAD;
            d_pulse <= 1'b1;
        end else begin
            d_pulse <= (pcnt > PCNT_W'(1));
            if (pcnt != '0) begin
                pcnt <= pcnt - PCNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/multi_edge_pulser.sv
// NCH independent debounced edge detectors with per-channel edge mode.
// Latency: SYNC_STAGES + DB_CYCLES clocks din->d_level/d_pulse; any_pulse is one OR after flops.
// Backpressure: none; every channel samples its input each clock.
//
// Ports:
//   clk, rst_n : clock (posedge) and asynchronous active-low reset
//   din        : [NCH-1:0] raw asynchronous inputs
//   mode       : [NCH-1:0] edge_mode_t per-channel edge select
//   d_pulse    : [NCH-1:0] registered one-shots
//   d_level    : [NCH-1:0] debounced levels
//   any_pulse  : OR of d_pulse
module multi_edge_pulser
    import multi_edge_pulser_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 4,
    parameter int PULSE_LEN   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic       [NCH-1:0] din,
    input  edge_mode_t [NCH-1:0] mode,
    output logic       [NCH-1:0] d_pulse,
    output logic       [NCH-1:0] d_level,
    output logic                 any_pulse
);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        edge_pulser_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_CYCLES   (DB_CYCLES),
            .PULSE_LEN   (PULSE_LEN)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .din     (din[i]),
            .mode    (mode[i]),
            .d_pulse (d_pulse[i]),
            .d_level (d_level[i])
        );
    end

    assign any_pulse = |d_pulse;

endmodule

// File: tb/tb_multi_edge_pulser.sv
module tb_multi_edge_pulser;
    import multi_edge_pulser_pkg::*;

    localparam int NCH = 4;
    // Instance A: default parameters. Instance B: fast debounce, long pulse.
    localparam int A_SYNC = 2, A_DB = 4, A_PL = 1;
    localparam int B_SYNC = 2, B_DB = 1, B_PL = 5;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic       [NCH-1:0] din = '0;
    edge_mode_t [NCH-1:0] mode;
    logic       [NCH-1:0] pul_a, lvl_a, pul_b, lvl_b;
    logic                 any_a, any_b;

    always #5 clk = ~clk;

    multi_edge_pulser #(.NCH(NCH), .SYNC_STAGES(A_SYNC), .DB_CYCLES(A_DB), .PULSE_LEN(A_PL)) u_a (
        .clk(clk), .rst_n(rst_n), .din(din), .mode(mode),
        .d_pulse(pul_a), .d_level(lvl_a), .any_pulse(any_a));

    multi_edge_pulser #(.NCH(NCH), .SYNC_STAGES(B_SYNC), .DB_CYCLES(B_DB), .PULSE_LEN(B_PL)) u_b (
        .clk(clk), .rst_n(rst_n), .din(din), .mode(mode),
        .d_pulse(pul_b), .d_level(lvl_b), .any_pulse(any_b));

    typedef struct {
        logic [NCH-1:0] lvl_a, pul_a, lvl_b, pul_b;
        logic           any_a, any_b;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: din history per channel (bit i = din i clocks ago),
    // current accepted level, and last cycle a pulse must still be high.
    logic [7:0] hist [2][NCH];
    logic       lvl  [2][NCH];
    int         pend [2][NCH];
    int         k;

    function automatic void cmp(input string nm, input logic [NCH-1:0] act, input logic [NCH-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at t=%0t: got %b expected %b", nm, $time, act, expv);
        end
    endfunction

    task automatic model_reset();
        for (int n = 0; n < 2; n++) begin
            for (int c = 0; c < NCH; c++) begin
                hist[n][c] = '0;
                lvl[n][c]  = 1'b0;
                pend[n][c] = -100;
            end
        end
        k = 0;
    endtask

    // Expected outputs just after posedge k, with din/mode as driven for that edge.
    // A level is accepted once the last DB samples seen by the debouncer
    // (din delayed by SYNC clocks) all disagree with the current level; a
    // qualified acceptance keeps the pulse high for PL clocks starting there.
    task automatic model_step(output exp_t e);
        logic [NCH-1:0] lv [2];
        logic [NCH-1:0] pv [2];
        logic [1:0]     mb;
        int sy, db, pl;
        bit all_diff;
        k++;
        for (int n = 0; n < 2; n++) begin
            sy = (n == 0) ? A_SYNC : B_SYNC;
            db = (n == 0) ? A_DB   : B_DB;
            pl = (n == 0) ? A_PL   : B_PL;
            for (int c = 0; c < NCH; c++) begin
                hist[n][c] = {hist[n][c][6:0], din[c]};
                all_diff = 1'b1;
                for (int m = 0; m < db; m++) begin
                    if (hist[n][c][sy+m] == lvl[n][c]) all_diff = 1'b0;
                end
                if (all_diff) begin
                    lvl[n][c] = ~lvl[n][c];
                    mb = mode[c];
                    if (lvl[n][c] ? mb[MODE_RISE_BIT] : mb[MODE_FALL_BIT]) pend[n][c] = k + pl - 1;
                end
                lv[n][c] = lvl[n][c];
                pv[n][c] = (k <= pend[n][c]);
            end
        end
        e.lvl_a = lv[0]; e.pul_a = pv[0]; e.any_a = |pv[0];
        e.lvl_b = lv[1]; e.pul_b = pv[1]; e.any_b = |pv[1];
    endtask

    // Monitor: one expected entry per clock edge while out of reset.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst_n) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_underflow at t=%0t: got empty queue expected an entry", $time);
            end else begin
                e = exp_q.pop_front();
                cmp("a_d_level",   lvl_a, e.lvl_a);
                cmp("a_d_pulse",   pul_a, e.pul_a);
                cmp("a_any_pulse", {3'b0, any_a}, {3'b0, e.any_a});
                cmp("b_d_level",   lvl_b, e.lvl_b);
                cmp("b_d_pulse",   pul_b, e.pul_b);
                cmp("b_any_pulse", {3'b0, any_b}, {3'b0, e.any_b});
            end
        end
    end

    task automatic drive(input logic [NCH-1:0] d, input edge_mode_t [NCH-1:0] m);
        exp_t e;
        @(negedge clk);
        rst_n = 1'b1;
        din   = d;
        mode  = m;
        model_step(e);
        exp_q.push_back(e);
    endtask

    task automatic cyc(input logic [NCH-1:0] d, input edge_mode_t [NCH-1:0] m, input int n);
        for (int i = 0; i < n; i++) drive(d, m);
    endtask

    // Asynchronous reset away from any clock edge; outputs must clear at once.
    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        cmp("rst_a_d_level", lvl_a, '0);
        cmp("rst_a_d_pulse", pul_a, '0);
        cmp("rst_a_any",     {3'b0, any_a}, '0);
        cmp("rst_b_d_level", lvl_b, '0);
        cmp("rst_b_d_pulse", pul_b, '0);
        cmp("rst_b_any",     {3'b0, any_b}, '0);
        model_reset();
        repeat (2) @(posedge clk);
    endtask

    initial begin
        edge_mode_t [NCH-1:0] m;
        logic [NCH-1:0] d;
        int rst_at;

        mode = {EDGE_OFF, EDGE_OFF, EDGE_OFF, EDGE_OFF};
        model_reset();
        #2;
        cmp("init_a_d_level", lvl_a, '0);
        cmp("init_a_d_pulse", pul_a, '0);
        cmp("init_b_d_pulse", pul_b, '0);
        repeat (2) @(posedge clk);

        // ch3 off, ch2 both, ch1 both, ch0 rise
        m = {EDGE_OFF, EDGE_BOTH, EDGE_BOTH, EDGE_RISE};
        cyc(4'b0000, m, 4);
        cyc(4'b0001, m, 12);                       // ch0 rising edge, held
        cyc(4'b0011, m, 3);  cyc(4'b0001, m, 10);  // ch1 3-cycle glitch
        cyc(4'b0011, m, 4);  cyc(4'b0001, m, 12);  // ch1 4-cycle high
        cyc(4'b0101, m, 8);  cyc(4'b0001, m, 12);  // ch2 rise then fall
        m[2] = EDGE_FALL;
        cyc(4'b0101, m, 8);  cyc(4'b0001, m, 12);  // ch2 fall only
        m[2] = EDGE_BOTH;
        for (int i = 0; i < 6; i++) begin          // ch2 toggle every 2 cycles
            cyc(4'b0101, m, 2);
            cyc(4'b0001, m, 2);
        end
        cyc(4'b0001, m, 10);
        cyc(4'b1001, m, 8);  cyc(4'b0001, m, 8);   // ch3 off: level only
        m[2] = EDGE_RISE;                          // mode change mid-pulse
        cyc(4'b0101, m, 4);  m[2] = EDGE_OFF; cyc(4'b0101, m, 8);

        // Reset mid-pulse, then inputs held high across release.
        m = {EDGE_BOTH, EDGE_BOTH, EDGE_BOTH, EDGE_BOTH};
        cyc(4'b1111, m, 5);
        do_reset();
        cyc(4'b1111, m, 10);
        cyc(4'b0000, m, 10);

        // Randomised phase with one asynchronous reset somewhere inside.
        d = '0;
        rst_at = $urandom_range(300, 1500);
        for (int i = 0; i < 2000; i++) begin
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 5) == 0) d[c] = ~d[c];
                if ($urandom_range(0, 40) == 0) m[c] = edge_mode_t'($urandom_range(0, 3));
            end
            drive(d, m);
            if (i == rst_at) do_reset();
        end

        @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
